fre_meas_sched: RTL and testbench
=================================

FRE_MEAS_SCHED -- requirements
Module: fre_meas_sched

Interface
REQ-001 Parameter NCH, default 4, number of requesters sharing one frequency-measurement engine.
REQ-002 Parameter GATE_DEF, default 400_000_000, gate length in sys_clk cycles used when gate_len is 0.
REQ-003 Parameter TO_MARGIN, default 1024, extra sys_clk cycles allowed past the gate before timeout.
REQ-004 sys_clk  input  1  sole clock, 200 MHz.
REQ-005 rst  input  1  reset, asynchronous assert, active-high.
REQ-006 req  input  NCH  per-requester level request.
REQ-007 gate_len  input  32  requested gate length in cycles, sampled at grant.
REQ-008 grant  output  NCH  one-hot owner of the engine; all-zero when idle.
REQ-009 eng_sel  output  clog2(NCH)  engine input-clock mux select.
REQ-010 eng_gate  output  32  gate length applied to the engine.
REQ-011 eng_start  output  1  single-cycle engine start pulse.
REQ-012 eng_done  input  1  single-cycle engine completion pulse.
REQ-013 eng_cnt_sys / eng_cnt_ext  input  64 each  engine reference and external counts, valid with eng_done.
REQ-014 res_valid  output  1  result valid; res_ready input 1 accepts.
REQ-015 res_ch  output  clog2(NCH)  channel of the result.
REQ-016 res_cnt_sys / res_cnt_ext  output  64 each  captured counts.
REQ-017 res_err  output  1  result is a timeout or zero-count error.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ARB, START, WAIT, RESULT; encoding in the package.
REQ-020 IDLE -> ARB when any req bit is high; stays in IDLE otherwise.
REQ-021 ARB, 1 cycle: round-robin pick starting at ptr+1 mod NCH; sets grant, eng_sel, and eng_gate (gate_len, or GATE_DEF if gate_len is 0); ptr <= winner; if req has gone all-zero, return to IDLE.
REQ-022 START, 1 cycle: eng_start=1; load the timeout counter with eng_gate+TO_MARGIN using 33-bit arithmetic with no wrap.
REQ-023 WAIT: decrement the timeout counter each cycle; eng_done -> capture counts, res_err=(eng_cnt_sys==0 or eng_cnt_ext==0), go to RESULT.
REQ-024 In WAIT, a timeout counter of 0 without eng_done -> counts captured as 0, res_err=1, go to RESULT; if eng_done arrives in the same cycle, eng_done wins.
REQ-025 eng_done outside WAIT is ignored.
REQ-026 RESULT: res_valid=1 and all res_* stable until res_valid&&res_ready; then go to IDLE the next cycle and clear grant.
REQ-027 Dropping req for the owning channel after ARB does not abort the measurement; the result is still delivered.
REQ-028 grant, eng_sel and eng_gate are held constant from ARB through RESULT.
REQ-029 Latency: req rise in IDLE -> eng_start after 2 cycles (ARB, START); eng_done -> res_valid after 1 cycle.
REQ-030 No channel is granted twice in a row while another channel requests.

Reset
REQ-031 rst high: state=IDLE, ptr=NCH-1 so channel 0 wins first, grant=0, eng_start=0, eng_sel=0, eng_gate=0, res_valid=0, res_err=0, res_ch=0, res_cnt_*=0, busy=0, timeout counter=0.
REQ-032 rst mid-measurement abandons it without emitting a result; later engine outputs are ignored until a new START.

Structure
REQ-033 Package fre_meas_pkg holds the FSM state type, CLK_FS=200_000_000, the count width 64, and the gate width 32.
REQ-034 Sub-module rr_arb (NCH-wide, request+pointer in, one-hot grant out, combinational) performs the round-robin pick.

Verification
REQ-035 req=4'b0001, gate_len=0 -> eng_gate=400_000_000, eng_start 2 cycles later; eng_done with 200_000_000/1_000_000 -> res_ch=0, res_err=0, same counts.
REQ-036 req=4'b1111 held, 4 measurements -> res_ch sequence 0,1,2,3.
REQ-037 gate_len=100, no eng_done -> res_valid exactly 100+1024 cycles after eng_start, res_err=1, counts 0.
REQ-038 eng_done with eng_cnt_ext=0 -> res_err=1; hold res_ready=0 for 10 cycles -> outputs stable, no new eng_start.
REQ-039 rst pulsed during WAIT, then a late eng_done -> res_valid stays 0, grant=0, busy=0.
REQ-040 eng_done and timeout expiring in the same cycle -> res_err=0 and the engine counts are captured.

Source files
------------

// File: rtl/fre_meas_pkg.sv
// fre_meas_pkg: shared definitions for the frequency-measurement scheduler.
//   state_t : scheduler FSM encoding
//   CLK_FS  : sys_clk frequency in Hz
//   CNT_W   : width of the engine reference/external counts
//   GATE_W  : width of the gate-length field
package fre_meas_pkg;

  localparam int CLK_FS = 200_000_000;
  localparam int CNT_W  = 64;
  localparam int GATE_W = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

endpackage

// File: rtl/fre_meas_sched_rr_arb.sv
// rr_arb: combinational round-robin picker.
//   req     : per-channel request
//   ptr     : last winner; search starts at ptr+1 mod NCH
//   gnt     : one-hot winner, zero when no request
//   gnt_idx : binary index of the winner
module rr_arb #(
  parameter int NCH = 4,
  parameter int SW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [SW-1:0]  gnt_idx
);

  logic [SW-1:0] idx;

  // Scan from the farthest channel to the nearest; the channel right after
  // ptr is written last and therefore wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int off = NCH; off >= 1; off--) begin
      idx = SW'((int'(ptr) + off) % NCH);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fre_meas_sched.sv
// fre_meas_sched: shares one frequency-measurement engine among NCH requesters.
//   sys_clk, rst            : clock, async active-high reset
//   req, gate_len           : level requests; gate length sampled at grant (0 = GATE_DEF)
//   grant, eng_sel, eng_gate: owner (one-hot), engine clock mux select, applied gate
//   eng_start, eng_done     : engine start pulse / completion pulse
//   eng_cnt_sys/ext         : engine counts, valid with eng_done
//   res_valid/res_ready     : result handshake; res_ch, res_cnt_*, res_err held until accepted
//   busy                    : high outside IDLE
module fre_meas_sched
  import fre_meas_pkg::*;
#(
  parameter int  NCH       = 4,
  parameter int  GATE_DEF  = 2 * CLK_FS,
  parameter int  TO_MARGIN = 1024,
  localparam int SW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [GATE_W-1:0] gate_len,
  output logic [NCH-1:0]    grant,
  output logic [SW-1:0]     eng_sel,
  output logic [GATE_W-1:0] eng_gate,
  output logic              eng_start,
  input  logic              eng_done,
  input  logic [CNT_W-1:0]  eng_cnt_sys,
  input  logic [CNT_W-1:0]  eng_cnt_ext,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SW-1:0]     res_ch,
  output logic [CNT_W-1:0]  res_cnt_sys,
  output logic [CNT_W-1:0]  res_cnt_ext,
  output logic              res_err,
  busy
);

  // Expiry is flagged while the counter still holds 2: the START cycle and the
  // RESULT register stage each take one cycle of the budget, so res_valid
  // rises exactly eng_gate+TO_MARGIN cycles after eng_start.
  localparam logic [GATE_W:0] TMO_FIRE = (GATE_W+1)'(2);

  state_t              state_q, state_d;
  logic [SW-1:0]       ptr_q, arb_idx;
  logic [NCH-1:0]      arb_gnt;
  logic [GATE_W:0]     tmo_q;
  logic                expire;

  rr_arb #(.NCH(NCH), .SW(SW)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign expire = (tmo_q <= TMO_FIRE);

  always_comb begin
    state_d   = state_q;
    eng_start = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (|req) state_d = S_ARB;
      end
      S_ARB:    state_d = (|req) ? S_START : S_IDLE;
      S_START: begin
        eng_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT:   if (eng_done || expire) state_d = S_RESULT;
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= SW'(NCH - 1);
      grant       <= '0;
      eng_sel     <= '0;
      eng_gate    <= '0;
      tmo_q       <= '0;
      res_ch      <= '0;
      res_cnt_sys <= '0;
      res_cnt_ext <= '0;
      res_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_ARB: if (|req) begin
          grant    <= arb_gnt;
          eng_sel  <= arb_idx;
          ptr_q    <= arb_idx;
          eng_gate <= (gate_len == '0) ? GATE_W'(GATE_DEF) : gate_len;
        end
        S_START: tmo_q <= {1'b0, eng_gate} + (GATE_W+1)'(TO_MARGIN);
        S_WAIT: begin
          if (tmo_q != '0) tmo_q <= tmo_q - 1'b1;
          // A completion in the expiry cycle still counts as a real result.
          if (eng_done) begin
            res_ch      <= eng_sel;
            res_cnt_sys <= eng_cnt_sys;
            res_cnt_ext <= eng_cnt_ext;
            res_err     <= (eng_cnt_sys == '0) || (eng_cnt_ext == '0);
          end else if (expire) begin
            res_ch      <= eng_sel;
            res_cnt_sys <= '0;
            res_cnt_ext <= '0;
            res_err     <= 1'b1;
          end
        end
        S_RESULT: if (res_ready) grant <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fre_meas_sched.sv
// tb_fre_meas_sched: directed bench with a result scoreboard. Stimulus pushes
// the expected result when a measurement starts; the monitor pops and compares
// on every accepted result.
module tb_fre_meas_sched;

  localparam int NCH = 4;

  logic        sys_clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] gate_len;
  logic [3:0]  grant;
  logic [1:0]  eng_sel;
  logic [31:0] eng_gate;
  logic        eng_start;
  logic        eng_done;
  logic [63:0] eng_cnt_sys, eng_cnt_ext;
  logic        res_valid, res_ready;
  logic [1:0]  res_ch;
  logic [63:0] res_cnt_sys, res_cnt_ext;
  logic        res_err, busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          ch;
    logic [63:0] s;
    logic [63:0] e;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  fre_meas_sched #(.NCH(NCH)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .req         (req),
    .gate_len    (gate_len),
    .grant       (grant),
    .eng_sel     (eng_sel),
    .eng_gate    (eng_gate),
    .eng_start   (eng_start),
    .eng_done    (eng_done),
    .eng_cnt_sys (eng_cnt_sys),
    .eng_cnt_ext (eng_cnt_ext),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_ch      (res_ch),
    .res_cnt_sys (res_cnt_sys),
    .res_cnt_ext (res_cnt_ext),
    .res_err     (res_err),
    .busy        (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Monitor: compare every accepted result against the oldest expectation.
  always @(negedge sys_clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual_ch=%0d required=none", res_ch);
      end else begin
        mon_e = sb.pop_front();
        chk("res_ch",      64'(res_ch),  64'(mon_e.ch));
        chk("res_cnt_sys", res_cnt_sys,  mon_e.s);
        chk("res_cnt_ext", res_cnt_ext,  mon_e.e);
        chk("res_err",     64'(res_err), 64'(mon_e.err));
      end
    end
  end

  // One measurement: wait for eng_start, pulse eng_done done_dly cycles later
  // (0 = never), and check result latency measured from the eng_start cycle.
  task automatic run_meas(input string nm, input int ch, input logic [31:0] gate,
                          input logic [63:0] cs, input logic [63:0] ce,
                          input int done_dly, input logic err, input int lat_exp,
                          input bit drop, output int start_n);
    exp_t e;
    int   lat;
    start_n = 0;
    do begin
      @(negedge sys_clk);
      start_n++;
    end while (!eng_start && start_n < 20);
    chk({nm, "_start_seen"}, 64'(eng_start), 64'd1);
    if (!eng_start) return;
    chk({nm, "_eng_gate"}, 64'(eng_gate), 64'(gate));
    chk({nm, "_eng_sel"},  64'(eng_sel),  64'(ch));
    chk({nm, "_grant"},    64'(grant),    64'(1) << ch);
    e.ch  = ch;
    e.s   = (done_dly > 0) ? cs : 64'd0;
    e.e   = (done_dly > 0) ? ce : 64'd0;
    e.err = err;
    sb.push_back(e);
    lat = 0;
    for (int k = 1; k <= lat_exp + 5; k++) begin
      @(posedge sys_clk);
      #1;
      if (k == 1 && drop) req = '0;
      eng_done    = (k == done_dly);
      eng_cnt_sys = cs;
      eng_cnt_ext = ce;
      @(negedge sys_clk);
      if (res_valid) begin
        lat = k;
        break;
      end
    end
    eng_done = 1'b0;
    chk({nm, "_latency"},    64'(lat),      64'(lat_exp));
    chk({nm, "_grant_hold"}, 64'(grant),    64'(1) << ch);
    chk({nm, "_gate_hold"},  64'(eng_gate), 64'(gate));
  endtask

  initial begin
    int   n;
    logic ok;
    logic bv, bb, bg, bs;
    rst = 1'b1; req = '0; gate_len = '0; eng_done = 1'b0;
    eng_cnt_sys = '0; eng_cnt_ext = '0; res_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge sys_clk);
    chk("rst_grant",     64'(grant),     64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_eng_start", 64'(eng_start), 64'd0);
    chk("rst_eng_sel",   64'(eng_sel),   64'd0);
    chk("rst_eng_gate",  64'(eng_gate),  64'd0);
    chk("rst_res_ch",    64'(res_ch),    64'd0);
    chk("rst_res_err",   64'(res_err),   64'd0);
    chk("rst_res_cnt",   res_cnt_sys | res_cnt_ext, 64'd0);
    @(posedge sys_clk);
    #1 rst = 1'b0;

    // Round robin with all channels requesting: 0,1,2,3
    req = 4'b1111; gate_len = 32'd50;
    for (int i = 0; i < 4; i++)
      run_meas("rr", i, 32'd50, 64'(1000 + i), 64'(7 + i), 3, 1'b0, 4, (i == 3), n);

    // Default gate, nominal counts, start latency from an IDLE request
    @(posedge sys_clk); #1;
    req = 4'b0001; gate_len = 32'd0;
    run_meas("def", 0, 32'd400_000_000, 64'd200_000_000, 64'd1_000_000, 1, 1'b0, 2, 1'b1, n);
    chk("req_to_start_cycles", 64'(n - 1), 64'd2);

    // Timeout: no eng_done, result 100+1024 cycles after eng_start
    @(posedge sys_clk); #1;
    req = 4'b0010; gate_len = 32'd100;
    run_meas("tmo", 1, 32'd100, 64'd123, 64'd456, 0, 1'b1, 1124, 1'b1, n);

    // eng_done in the expiry cycle wins
    @(posedge sys_clk); #1;
    req = 4'b0100; gate_len = 32'd100;
    run_meas("tie", 2, 32'd100, 64'd5, 64'd9, 1123, 1'b0, 1124, 1'b1, n);

    // Zero external count, result held under backpressure
    @(posedge sys_clk); #1;
    res_ready = 1'b0; req = 4'b1000; gate_len = 32'd20;
    run_meas("hold", 3, 32'd20, 64'd77, 64'd0, 2, 1'b1, 3, 1'b0, n);
    ok = 1'b1; bs = 1'b0;
    repeat (10) begin
      @(negedge sys_clk);
      ok &= res_valid && (res_ch == 2'd3) && res_err && (res_cnt_sys == 64'd77)
            && (res_cnt_ext == 64'd0) && (grant == 4'b1000) && (eng_gate == 32'd20);
      bs |= eng_start;
    end
    chk("hold_stable",   64'(ok), 64'd1);
    chk("hold_no_start", 64'(bs), 64'd0);
    @(posedge sys_clk); #1;
    res_ready = 1'b1; req = '0;
    @(negedge sys_clk);
    @(posedge sys_clk); #1;

    // Reset during WAIT, then a late eng_done
    req = 4'b0001; gate_len = 32'd1000;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!eng_start && n < 20);
    chk("rstw_start_seen", 64'(eng_start), 64'd1);
    @(posedge sys_clk); #1;
    req = '0;
    repeat (5) @(posedge sys_clk);
    #1 rst = 1'b1;
    @(negedge sys_clk);
    chk("rstw_busy_in_rst", 64'(busy), 64'd0);
    @(posedge sys_clk); #1;
    rst = 1'b0;
    eng_done = 1'b1; eng_cnt_sys = 64'd321; eng_cnt_ext = 64'd654;
    @(posedge sys_clk); #1;
    eng_done = 1'b0;
    bv = 1'b0; bb = 1'b0; bg = 1'b0; bs = 1'b0;
    repeat (10) begin
      @(negedge sys_clk);
      bv |= res_valid;
      bb |= busy;
      bg |= (grant != '0);
      bs |= eng_start;
    end
    chk("rstw_res_valid", 64'(bv), 64'd0);
    chk("rstw_busy",      64'(bb), 64'd0);
    chk("rstw_grant",     64'(bg), 64'd0);
    chk("rstw_eng_start", 64'(bs), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
